// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron.
// Integrates an unsigned synaptic trace into a membrane potential with a
// shift-based leak. When the potential reaches threshold, the neuron emits a
// one-cycle spike, clears the potential and enters a refractory period.
// The design uses two states:
//   state   | meaning
//   S_INTEG | integrating input and leaking; fires on threshold crossing
//   S_REFR  | refractory: potential held at 0, inputs dropped and counted
module lif_neuron #(
  parameter int W_IN       = 8,
  parameter int W_V        = 16,
  parameter int THRESH     = 1000,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4,
  parameter int W_CNT      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             psc_valid,
  input  logic [W_IN-1:0]  psc_in,
  output logic             spike_out,
  output logic [W_V-1:0]   v_mem,
  output logic             refractory,
  output logic [W_CNT-1:0] spike_count,
  output logic [W_CNT-1:0] drop_count
);

  // The refractory counter needs at least one bit, even when REFRAC is 0.
  localparam int W_R = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

  localparam logic [W_V-1:0]   THRESH_V = W_V'(THRESH);
  localparam logic [W_R-1:0]   REFRAC_R = W_R'(REFRAC);
  localparam logic [W_R-1:0]   RCNT_ONE = W_R'(1);
  localparam logic [W_CNT-1:0] CNT_MAX  = '1;

  typedef enum logic {
    S_INTEG = 1'b0,
    S_REFR  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W_V-1:0]   v_q, v_d;
  logic             spike_q, spike_d;
  logic [W_R-1:0]   rcnt_q, rcnt_d;
  logic [W_CNT-1:0] spike_count_q, spike_count_d;
  logic [W_CNT-1:0] drop_count_q, drop_count_d;

  logic [W_V:0]     v_ext;
  logic [W_V:0]     leak;
  logic [W_V:0]     add;
  logic [W_V:0]     v_sum;
  logic [W_V-1:0]   v_next;
  logic             fire;

  // Leak-and-integrate datapath, one bit wider than v so the sum can saturate.
  // v - (v >> LEAK_SHIFT) never underflows, and adding one input sample can
  // at most set the extra bit, so W_V+1 bits always suffice.
  always_comb begin
    v_ext  = {1'b0, v_q};
    leak   = v_ext >> LEAK_SHIFT;
    add    = psc_valid ? (W_V + 1)'(psc_in) : '0;
    v_sum  = v_ext - leak + add;
    v_next = v_sum[W_V] ? {W_V{1'b1}} : v_sum[W_V-1:0];
    fire   = (v_next >= THRESH_V);
  end

  // Next-state and next-output logic; en=0 holds everything except the spike.
  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    spike_d       = 1'b0;
    rcnt_d        = rcnt_q;
    spike_count_d = spike_count_q;
    drop_count_d  = drop_count_q;

    if (en) begin
      case (state_q)
        S_INTEG: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = '0;
            if (spike_count_q != CNT_MAX) begin
              spike_count_d = spike_count_q + 1'b1;
            end
            if (REFRAC > 0) begin
              state_d = S_REFR;
              rcnt_d  = REFRAC_R;
            end
          end else begin
            v_d = v_next;
          end
        end

        S_REFR: begin
          v_d    = '0;
          rcnt_d = rcnt_q - 1'b1;
          if (psc_valid && (drop_count_q != CNT_MAX)) begin
            drop_count_d = drop_count_q + 1'b1;
          end
          if (rcnt_q == RCNT_ONE) begin
            state_d = S_INTEG;
          end
        end

        default: begin
          state_d = S_INTEG;
          v_d     = '0;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INTEG;
      v_q           <= '0;
      spike_q       <= 1'b0;
      rcnt_q        <= '0;
      spike_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      spike_q       <= spike_d;
      rcnt_q        <= rcnt_d;
      spike_count_q <= spike_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign spike_out   = spike_q;
  assign v_mem       = v_q;
  assign refractory  = (state_q == S_REFR);
  assign spike_count = spike_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default instance, a LEAK_SHIFT=0 instance
// and a small-counter, always-firing instance share the same stimulus.
module tb_lif_neuron;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       psc_valid;
  logic [7:0] psc_in;

  logic        spike_out, refractory;
  logic [15:0] v_mem, spike_count, drop_count;

  logic        l0_spike, l0_refr;
  logic [15:0] l0_v, l0_sc, l0_dc;

  logic        s_spike, s_refr;
  logic [15:0] s_v;
  logic [1:0]  s_sc, s_dc;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lif_neuron dut (
    .clk(clk), .reset(reset), .en(en), .psc_valid(psc_valid), .psc_in(psc_in),
    .spike_out(spike_out), .v_mem(v_mem), .refractory(refractory),
    .spike_count(spike_count), .drop_count(drop_count)
  );

  lif_neuron #(.LEAK_SHIFT(0)) dut_l0 (
    .clk(clk), .reset(reset), .en(en), .psc_valid(psc_valid), .psc_in(psc_in),
    .spike_out(l0_spike), .v_mem(l0_v), .refractory(l0_refr),
    .spike_count(l0_sc), .drop_count(l0_dc)
  );

  lif_neuron #(.W_CNT(2), .THRESH(1), .REFRAC(0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .psc_valid(psc_valid), .psc_in(psc_in),
    .spike_out(s_spike), .v_mem(s_v), .refractory(s_refr),
    .spike_count(s_sc), .drop_count(s_dc)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; psc_valid = 1'b1; psc_in = 8'd255;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({spike_out, refractory, v_mem, spike_count, drop_count} !== 50'd0) begin
      tests_failed++;
      $display("FAIL reset_default: spike=%0b refr=%0b v=%0d sc=%0d dc=%0d, want all 0",
               spike_out, refractory, v_mem, spike_count, drop_count);
    end
    tests_run++;
    if ({l0_spike, l0_refr, l0_v, s_spike, s_refr, s_v, s_sc, s_dc} !== 40'd0) begin
      tests_failed++;
      $display("FAIL reset_variants: l0_v=%0d s_spike=%0b s_v=%0d s_sc=%0d, want all 0",
               l0_v, s_spike, s_v, s_sc);
    end
  endtask

  task automatic test_fire_refractory();
    logic [15:0] exp_v [5];
    exp_v = '{16'd255, 16'd479, 16'd675, 16'd846, 16'd996};
    do_reset();
    psc_valid = 1'b1; psc_in = 8'd255;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (v_mem !== exp_v[i] || spike_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL integ_%0d: v=%0d spike=%0b, want v=%0d spike=0",
                 i, v_mem, spike_out, exp_v[i]);
      end
    end
    step();
    tests_run++;
    if (spike_out !== 1'b1 || v_mem !== 16'd0 || spike_count !== 16'd1 || refractory !== 1'b1) begin
      tests_failed++;
      $display("FAIL fire: spike=%0b v=%0d sc=%0d refr=%0b, want 1 0 1 1",
               spike_out, v_mem, spike_count, refractory);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (refractory !== (i < 3) || v_mem !== 16'd0 || spike_out !== 1'b0 ||
          drop_count !== 16'(i + 1)) begin
        tests_failed++;
        $display("FAIL refr_%0d: refr=%0b v=%0d spike=%0b dc=%0d, want refr=%0b v=0 spike=0 dc=%0d",
                 i, refractory, v_mem, spike_out, drop_count, (i < 3), i + 1);
      end
    end
    step();
    tests_run++;
    if (v_mem !== 16'd255 || drop_count !== 16'd4 || spike_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL post_refr: v=%0d dc=%0d sc=%0d, want 255 4 1", v_mem, drop_count, spike_count);
    end
  endtask

  task automatic test_converge();
    bit saw_spike = 0;
    do_reset();
    psc_valid = 1'b1; psc_in = 8'd100;
    for (int i = 0; i < 300; i++) begin
      step();
      if (spike_out) saw_spike = 1;
    end
    tests_run++;
    if (v_mem < 16'd800 || v_mem > 16'd807) begin
      tests_failed++;
      $display("FAIL converge_v: v=%0d, want within [800,807]", v_mem);
    end
    tests_run++;
    if (saw_spike || spike_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL converge_nospike: saw_spike=%0b sc=%0d, want 0 0", saw_spike, spike_count);
    end
  endtask

  task automatic test_leak_floor();
    logic [15:0] prev;
    do_reset();
    psc_valid = 1'b1; psc_in = 8'd255;
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (v_mem !== 16'd996) begin
      tests_failed++;
      $display("FAIL leak_start: v=%0d, want 996", v_mem);
    end
    psc_valid = 1'b0;
    prev = 16'd996;
    for (int i = 0; i < 80; i++) begin
      step();
      tests_run++;
      if (v_mem > prev) begin
        tests_failed++;
        $display("FAIL leak_monotonic_%0d: v=%0d, want <= %0d", i, v_mem, prev);
      end
      prev = v_mem;
    end
    tests_run++;
    if (v_mem !== 16'd7) begin
      tests_failed++;
      $display("FAIL leak_floor: v=%0d, want 7", v_mem);
    end
  endtask

  task automatic test_leak_zero();
    logic        vld [4];
    logic [7:0]  din [4];
    logic [15:0] exp_v [4];
    vld   = '{1'b1, 1'b1, 1'b0, 1'b1};
    din   = '{8'd37, 8'd200, 8'd99, 8'd5};
    exp_v = '{16'd37, 16'd200, 16'd0, 16'd5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      psc_valid = vld[i]; psc_in = din[i];
      step();
      tests_run++;
      if (l0_v !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL leak0_%0d: v=%0d, want %0d", i, l0_v, exp_v[i]);
      end
    end
  endtask

  task automatic test_freeze_reset_refr();
    do_reset();
    psc_valid = 1'b1; psc_in = 8'd255;
    for (int i = 0; i < 6; i++) step();
    step();
    tests_run++;
    if (refractory !== 1'b1 || drop_count !== 16'd1 || spike_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL freeze_pre: refr=%0b dc=%0d sc=%0d, want 1 1 1", refractory, drop_count, spike_count);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (refractory !== 1'b1 || v_mem !== 16'd0 || drop_count !== 16'd1 || spike_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL freeze_%0d: refr=%0b v=%0d dc=%0d spike=%0b, want 1 0 1 0",
                 i, refractory, v_mem, drop_count, spike_out);
      end
    end
    en = 1'b1;
    step();
    step();
    tests_run++;
    if (refractory !== 1'b1 || drop_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL unfreeze: refr=%0b dc=%0d, want 1 3", refractory, drop_count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (refractory !== 1'b0 || spike_count !== 16'd0 || drop_count !== 16'd0 ||
        v_mem !== 16'd0 || spike_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_refr: refr=%0b sc=%0d dc=%0d v=%0d spike=%0b, want all 0",
               refractory, spike_count, drop_count, v_mem, spike_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    psc_valid = 1'b1; psc_in = 8'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if (s_spike !== 1'b1 || s_sc !== ((i < 2) ? 2'(i + 1) : 2'd3) || s_refr !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_%0d: spike=%0b sc=%0d refr=%0b, want 1 %0d 0",
                 i, s_spike, s_sc, s_refr, (i < 2) ? i + 1 : 3);
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; psc_valid = 1'b0; psc_in = 8'd0;
    #1;
    test_reset();
    test_fire_refractory();
    test_converge();
    test_leak_floor();
    test_leak_zero();
    test_freeze_reset_refr();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
